wb_counter_sequencer: RTL and testbench
=======================================

WB_COUNTER_SEQUENCER -- requirements
Module: wb_counter_sequencer

Interface
REQ-001 SHALL have parameter BITS, default 16, counter width (1..32).
REQ-002 SHALL have port wb_clk_i  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port wbs_cyc_i  input  1  Wishbone cycle.
REQ-005 SHALL have port wbs_stb_i  input  1  Wishbone strobe.
REQ-006 SHALL have port wbs_we_i  input  1  write enable.
REQ-007 SHALL have port wbs_sel_i  input  4  byte selects.
REQ-008 SHALL have port wbs_adr_i  input  32  address; only bits [3:2] decoded.
REQ-009 SHALL have port wbs_dat_i  input  32  write data.
REQ-010 SHALL have port wbs_ack_o  output  1  acknowledge.
REQ-011 SHALL have port wbs_dat_o  output  32  read data.
REQ-012 SHALL have port count_o  output  BITS  current count.
REQ-013 SHALL have port running_o  output  1  high while state is RUN.
REQ-014 SHALL have port irq_o  output  1  level interrupt, equals irq_pending.

Function
REQ-015 SHALL define valid = wbs_cyc_i & wbs_stb_i; wbs_ack_o SHALL rise the cycle after valid with ack low, stay high exactly one cycle, then drop (one wait state per access, no back-to-back ack).
REQ-016 SHALL commit writes and sample read data on the edge that raises wbs_ack_o; wbs_dat_o SHALL be 0 when ack is low.
REQ-017 Register map (adr[3:2]): 0 CTRL, 1 LOAD, 2 LIMIT, 3 STATUS.
REQ-018 CTRL write: bit0 START, bit1 STOP, bit2 IRQ_CLR (write-1 pulses, self-clearing), bit3 AUTO_RELOAD (stored); only applied if wbs_sel_i[0]; read returns {28'b0, AUTO_RELOAD, 3'b0}.
REQ-019 LOAD and LIMIT SHALL be BITS-wide R/W, byte-lane writes gated by wbs_sel_i; bits above BITS ignored on write, read as 0.
REQ-020 STATUS read-only: [1:0] state (IDLE=0, RUN=1, HOLD=2, DONE=3), [2] irq_pending, [31:16] count (zero-extended/truncated to 16 bits); writes ignored but acked.
REQ-021 FSM IDLE: START -> RUN with count <= LOAD.
REQ-022 FSM RUN: count increments by 1 per cycle modulo 2^BITS; STOP -> HOLD (count frozen, the stop edge does not increment).
REQ-023 In RUN when count == LIMIT: irq_pending <= 1; if AUTO_RELOAD, count <= LOAD and stay RUN; else -> DONE, count held at LIMIT.
REQ-024 FSM HOLD: START -> RUN resuming from held count (no reload); STOP ignored.
REQ-025 FSM DONE: START -> RUN with count <= LOAD; STOP ignored.
REQ-026 START and STOP in same write: STOP wins (RUN -> HOLD; other states unchanged).
REQ-027 LIMIT match and STOP on same edge: irq_pending set, STOP wins (-> HOLD, count per REQ-023 reload/hold value).
REQ-028 IRQ_CLR and new match on same edge: set wins, irq_pending stays 1.
REQ-029 LOAD write during RUN SHALL only affect next reload/start; LIMIT write takes effect next cycle; LIMIT below count SHALL wrap through 2^BITS-1 -> 0 until match.
REQ-030 count_o SHALL equal the internal count register (registered, no combinational path from bus).

Reset
REQ-031 On wb_rst_i high, immediately and asynchronously: state IDLE, count 0, LOAD 0, LIMIT all-ones, AUTO_RELOAD 0, irq_pending 0, wbs_ack_o 0, wbs_dat_o 0, running_o 0.
REQ-032 Reset mid-transaction SHALL abort it with no ack; first access after release behaves per REQ-015.

Verification
REQ-033 Write LOAD=5, LIMIT=8, CTRL=0x1 -> count 5,6,7,8 on successive cycles, state DONE, irq_o=1, count_o holds 8.
REQ-034 AUTO_RELOAD: CTRL=0x9 with LOAD=2, LIMIT=4 -> count sequence 2,3,4,2,3,4..., state stays RUN, irq_o=1 after first 4.
REQ-035 STOP at count 0x10 then START -> HOLD with count 0x10 frozen, then resume 0x11 (no reload).
REQ-036 CTRL write 0x3 in RUN -> HOLD; IRQ_CLR on match edge -> irq_o stays 1; IRQ_CLR later -> irq_o 0.
REQ-037 LIMIT=3 while count=0xFFF0 (BITS=16) -> wraps 0xFFFF -> 0 -> 3, then DONE.
REQ-038 Assert wb_rst_i during RUN and during pending ack -> all outputs per REQ-031 within the same cycle, no ack issued.

Source files
------------

// File: rtl/wb_counter_sequencer_if.sv
// Wishbone slave bus bundle for wb_counter_sequencer.
// The slave modport faces the counter and the master modport faces the bus initiator.
interface wb_counter_sequencer_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/wb_counter_sequencer.sv
// Wishbone-controlled counter sequencer: IDLE/RUN/HOLD/DONE FSM counting from LOAD to LIMIT,
// with optional auto-reload and a level interrupt on each LIMIT match.
module wb_counter_sequencer #(
   parameter int BITS = 16
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   wb_counter_sequencer_if.slave bus,
   output logic [BITS-1:0]      count_o,
   output logic                 running_o,
   output logic                 irq_o
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t          state_reg;
   logic [BITS-1:0] count_reg;
   logic [BITS-1:0] load_reg;
   logic [BITS-1:0] limit_reg;
   logic            auto_reload_reg;
   logic            irq_reg;
   logic            running_reg;
   logic            ack_reg;
   logic [31:0]     dat_o_reg;

   logic        valid;
   logic        access;
   logic        wr_access;
   logic [1:0]  reg_sel;
   logic        wr_ctrl;
   logic        wr_load;
   logic        wr_limit;
   logic        start;
   logic        stop;
   logic        irq_clr;
   logic        match;
   logic [31:0] load_ext;
   logic [31:0] limit_ext;
   logic [31:0] count_ext;
   logic [31:0] load_merged;
   logic [31:0] limit_merged;
   logic [31:0] rd_data;
   logic        unused_bits;

   // An access is accepted only while ack is low, which forces one wait state per transfer.
   assign valid     = bus.wbs_cyc_i & bus.wbs_stb_i;
   assign access    = valid & ~ack_reg;
   assign wr_access = access & bus.wbs_we_i;
   assign reg_sel   = bus.wbs_adr_i[3:2];

   assign wr_ctrl  = wr_access & (reg_sel == 2'd0) & bus.wbs_sel_i[0];
   assign wr_load  = wr_access & (reg_sel == 2'd1);
   assign wr_limit = wr_access & (reg_sel == 2'd2);
   assign start    = wr_ctrl & bus.wbs_dat_i[0];
   assign stop     = wr_ctrl & bus.wbs_dat_i[1];
   assign irq_clr  = wr_ctrl & bus.wbs_dat_i[2];
   assign match    = (count_reg == limit_reg);

   assign load_ext  = 32'(load_reg);
   assign limit_ext = 32'(limit_reg);
   assign count_ext = 32'(count_reg);

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign load_merged[8*gi +: 8]  = bus.wbs_sel_i[gi] ? bus.wbs_dat_i[8*gi +: 8] : load_ext[8*gi +: 8];
         assign limit_merged[8*gi +: 8] = bus.wbs_sel_i[gi] ? bus.wbs_dat_i[8*gi +: 8] : limit_ext[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      rd_data = 32'd0;
      case (reg_sel)
         2'd0: rd_data = {28'd0, auto_reload_reg, 3'b000};
         2'd1: rd_data = load_ext;
         2'd2: rd_data = limit_ext;
         2'd3: rd_data = {count_ext[15:0], 13'd0, irq_reg, state_reg};
      endcase
   end

   assign unused_bits = ^{load_merged, limit_merged, count_ext, bus.wbs_adr_i[31:4], bus.wbs_adr_i[1:0]};

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_reg       <= ST_IDLE;
         count_reg       <= '0;
         load_reg        <= '0;
         limit_reg       <= '1;
         auto_reload_reg <= 1'b0;
         irq_reg         <= 1'b0;
         running_reg     <= 1'b0;
         ack_reg         <= 1'b0;
         dat_o_reg       <= 32'd0;
      end else begin
         ack_reg   <= access;
         dat_o_reg <= (access && !bus.wbs_we_i) ? rd_data : 32'd0;
         if (wr_load)  load_reg        <= load_merged[BITS-1:0];
         if (wr_limit) limit_reg       <= limit_merged[BITS-1:0];
         if (wr_ctrl)  auto_reload_reg <= bus.wbs_dat_i[3];
         // Clear is written first so a simultaneous match below overrides it.
         if (irq_clr)  irq_reg         <= 1'b0;
         case (state_reg)
            ST_IDLE, ST_DONE: begin
               if (start && !stop) begin
                  state_reg   <= ST_RUN;
                  running_reg <= 1'b1;
                  count_reg   <= load_reg;
               end
            end
            ST_RUN: begin
               if (match) begin
                  irq_reg <= 1'b1;
                  if (auto_reload_reg) count_reg <= load_reg;
                  if (stop) begin
                     state_reg   <= ST_HOLD;
                     running_reg <= 1'b0;
                  end else if (!auto_reload_reg) begin
                     state_reg   <= ST_DONE;
                     running_reg <= 1'b0;
                  end
               end else if (stop) begin
                  state_reg   <= ST_HOLD;
                  running_reg <= 1'b0;
               end else begin
                  count_reg <= count_reg + BITS'(1);
               end
            end
            ST_HOLD: begin
               if (start && !stop) begin
                  state_reg   <= ST_RUN;
                  running_reg <= 1'b1;
               end
            end
         endcase
      end
   end

   assign bus.wbs_ack_o = ack_reg;
   assign bus.wbs_dat_o = dat_o_reg;
   assign count_o       = count_reg;
   assign running_o     = running_reg;
   assign irq_o         = irq_reg;
endmodule

// File: tb/tb_wb_counter_sequencer.sv
// Self-checking bench for wb_counter_sequencer: register-map vector table, hand-written
// corner sequences and randomized runs against a closed-form model of the count sequence.
module tb_wb_counter_sequencer;
   localparam int BITS = 16;
   localparam int MOD  = 65536;

   typedef struct {
      bit          we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [31:0] exp;
   } vec_t;

   logic            clk;
   logic            rst;
   logic [BITS-1:0] count_o;
   logic            running_o;
   logic            irq_o;
   int              n_cmp = 0;
   int              n_bad = 0;
   int              cyc_cnt = 0;
   int              commit_cyc = 0;

   wb_counter_sequencer_if bus();

   wb_counter_sequencer #(.BITS(BITS)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus),
      .count_o  (count_o),
      .running_o(running_o),
      .irq_o    (irq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
      end
   endtask

   // Closed-form expectation k cycles after the START commit edge.
   function automatic void model_run(input int l, input int m, input bit ar, input int k,
                                     output int ec, output bit er, output bit ei);
      int d;
      d  = (m - l + MOD) % MOD;
      ei = (k > d);
      if (ar) begin
         ec = (l + (k % (d + 1))) % MOD;
         er = 1'b1;
      end else begin
         ec = (l + ((k < d) ? k : d)) % MOD;
         er = (k <= d);
      end
   endfunction

   task automatic bus_xfer(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdata);
      int waited;
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = we;
      bus.wbs_adr_i = adr;
      bus.wbs_dat_i = dat;
      bus.wbs_sel_i = sel;
      waited = 0;
      while (waited < 4) begin
         @(posedge clk);
         #1;
         waited++;
         if (bus.wbs_ack_o) break;
      end
      check("ack_latency", waited, 1);
      check("ack_seen", bus.wbs_ack_o, 1'b1);
      rdata      = bus.wbs_dat_o;
      commit_cyc = cyc_cnt;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      @(posedge clk);
      #1;
      check("ack_drop", bus.wbs_ack_o, 1'b0);
      check("dat_idle", bus.wbs_dat_o, 32'd0);
      $display("xfer we=%0d adr=%h dat=%h sel=%h rdata=%h commit=%0d", we, adr, dat, sel, rdata, commit_cyc);
   endtask

   task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
      logic [31:0] rd_unused;
      bus_xfer(1'b1, adr, dat, 4'hF, rd_unused);
   endtask

   task automatic rd_check(input string name, input logic [31:0] adr, input logic [31:0] exp);
      logic [31:0] r;
      bus_xfer(1'b0, adr, 32'd0, 4'hF, r);
      check(name, r, exp);
   endtask

   task automatic wait_cycle(input int c);
      while (cyc_cnt < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_run(input int l, input int m, input bit ar, input int s, input int e, input string tag);
      int ec;
      bit er, ei;
      while (cyc_cnt <= e) begin
         model_run(l, m, ar, cyc_cnt - s, ec, er, ei);
         check({tag, "_count"}, 32'(count_o), ec);
         check({tag, "_running"}, running_o, er);
         check({tag, "_irq"}, irq_o, ei);
         @(posedge clk);
         #1;
      end
   endtask

   vec_t vecs [0:22];

   initial begin
      int s;
      int c;
      logic [31:0] r;
      vecs[0]  = '{0, 32'h0000_0004, 32'h0,          4'hF, 32'h0000_0000};
      vecs[1]  = '{0, 32'h0000_0008, 32'h0,          4'hF, 32'h0000_FFFF};
      vecs[2]  = '{0, 32'h0000_0000, 32'h0,          4'hF, 32'h0000_0000};
      vecs[3]  = '{0, 32'h0000_000C, 32'h0,          4'hF, 32'h0000_0000};
      vecs[4]  = '{1, 32'h0000_0004, 32'hDEAD_1234,  4'hF, 32'h0};
      vecs[5]  = '{0, 32'h0000_0004, 32'h0,          4'hF, 32'h0000_1234};
      vecs[6]  = '{1, 32'h0000_0004, 32'h0000_AB00,  4'h2, 32'h0};
      vecs[7]  = '{0, 32'h0000_0F04, 32'h0,          4'hF, 32'h0000_AB34};
      vecs[8]  = '{1, 32'h0000_0008, 32'h0000_0077,  4'h1, 32'h0};
      vecs[9]  = '{0, 32'h0000_0008, 32'h0,          4'hF, 32'h0000_FF77};
      vecs[10] = '{1, 32'h0000_0008, 32'h0012_5500,  4'hC, 32'h0};
      vecs[11] = '{0, 32'h0000_0008, 32'h0,          4'hF, 32'h0000_FF77};
      vecs[12] = '{1, 32'h0000_0000, 32'h0000_0008,  4'h0, 32'h0};
      vecs[13] = '{0, 32'h0000_0000, 32'h0,          4'hF, 32'h0000_0000};
      vecs[14] = '{1, 32'h0000_0000, 32'h0000_0008,  4'h1, 32'h0};
      vecs[15] = '{0, 32'h0000_0000, 32'h0,          4'hF, 32'h0000_0008};
      vecs[16] = '{1, 32'h0000_000C, 32'hFFFF_FFFF,  4'hF, 32'h0};
      vecs[17] = '{0, 32'h0000_000C, 32'h0,          4'hF, 32'h0000_0000};
      vecs[18] = '{1, 32'h0000_0000, 32'h0000_000B,  4'h1, 32'h0};
      vecs[19] = '{0, 32'h0000_000C, 32'h0,          4'hF, 32'h0000_0000};
      vecs[20] = '{0, 32'h0000_0000, 32'h0,          4'hF, 32'h0000_0008};
      vecs[21] = '{1, 32'h0000_0000, 32'h0000_0000,  4'h1, 32'h0};
      vecs[22] = '{0, 32'h0000_0000, 32'h0,          4'hF, 32'h0000_0000};

      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      bus.wbs_sel_i = 4'h0;
      bus.wbs_adr_i = 32'd0;
      bus.wbs_dat_i = 32'd0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_count", 32'(count_o), 32'd0);
      check("rst_running", running_o, 1'b0);
      check("rst_irq", irq_o, 1'b0);
      check("rst_ack", bus.wbs_ack_o, 1'b0);
      check("rst_dat", bus.wbs_dat_o, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Register map vectors
      for (int i = 0; i <= 22; i++) begin
         bus_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, r);
         if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), r, vecs[i].exp);
      end
      check("vec_idle_running", running_o, 1'b0);

      // Count 5..8 then DONE with irq
      do_reset();
      wr(32'h4, 32'd5);
      wr(32'h8, 32'd8);
      wr(32'h0, 32'h1);
      s = commit_cyc;
      check("basic_start_count", 32'(count_o), 32'd6);
      check_run(5, 8, 1'b0, s, s + 8, "basic");
      rd_check("basic_status", 32'hC, 32'h0008_0007);

      // Auto reload 2,3,4,2,...
      do_reset();
      wr(32'h4, 32'd2);
      wr(32'h8, 32'd4);
      wr(32'h0, 32'h9);
      s = commit_cyc;
      check_run(2, 4, 1'b1, s, s + 12, "auto");

      // STOP at 0x10 then START resumes without reload
      do_reset();
      wr(32'h4, 32'h0C);
      wr(32'h8, 32'h100);
      wr(32'h0, 32'h1);
      s = commit_cyc;
      wait_cycle(s + 4);
      wr(32'h0, 32'h2);
      check("hold_count", 32'(count_o), 32'h10);
      check("hold_running", running_o, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("hold_frozen", 32'(count_o), 32'h10);
      rd_check("hold_status", 32'hC, 32'h0010_0002);
      wr(32'h0, 32'h1);
      check("resume_count", 32'(count_o), 32'h11);
      check("resume_running", running_o, 1'b1);

      // IRQ_CLR on the match edge loses, later IRQ_CLR wins
      do_reset();
      wr(32'h4, 32'd0);
      wr(32'h8, 32'd3);
      wr(32'h0, 32'h1);
      s = commit_cyc;
      wait_cycle(s + 3);
      wr(32'h0, 32'h4);
      check("clr_match_irq", irq_o, 1'b1);
      check("clr_match_count", 32'(count_o), 32'd3);
      check("clr_match_running", running_o, 1'b0);
      wr(32'h0, 32'h4);
      check("clr_later_irq", irq_o, 1'b0);
      // START+STOP while running goes to HOLD
      wr(32'h8, 32'h50);
      wr(32'h0, 32'h1);
      s = commit_cyc;
      wr(32'h0, 32'h3);
      c = commit_cyc;
      check("startstop_running", running_o, 1'b0);
      check("startstop_count", 32'(count_o), 32'(c - s - 1));
      rd_check("startstop_status", 32'hC, {16'(c - s - 1), 16'h0002});

      // LIMIT match and STOP on the same edge
      do_reset();
      wr(32'h4, 32'd0);
      wr(32'h8, 32'd3);
      wr(32'h0, 32'h1);
      s = commit_cyc;
      wait_cycle(s + 3);
      wr(32'h0, 32'h2);
      rd_check("matchstop_status", 32'hC, 32'h0003_0006);

      // LIMIT rewritten below count wraps through zero
      do_reset();
      wr(32'h4, 32'hFFF0);
      wr(32'h8, 32'hFFFF);
      wr(32'h0, 32'h1);
      s = commit_cyc;
      wr(32'h8, 32'd3);
      check_run(32'hFFF0, 3, 1'b0, s, s + 25, "wrap");

      // Back-to-back requests get alternating ack
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_adr_i = 32'hC;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("b2b_ack%0d", i), bus.wbs_ack_o, (i % 2 == 0) ? 32'd1 : 32'd0);
      end
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;

      // Asynchronous reset during RUN
      do_reset();
      wr(32'h4, 32'd0);
      wr(32'h8, 32'd2);
      wr(32'h0, 32'h9);
      s = commit_cyc;
      check_run(0, 2, 1'b1, s, s + 5, "prerst");
      #2 rst = 1'b1;
      #1;
      check("arst_count", 32'(count_o), 32'd0);
      check("arst_running", running_o, 1'b0);
      check("arst_irq", irq_o, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      rd_check("arst_limit", 32'h8, 32'h0000_FFFF);
      rd_check("arst_ctrl", 32'h0, 32'h0);

      // Reset while an access is pending, then first access after release
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_adr_i = 32'h8;
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      check("pend_rst_ack", bus.wbs_ack_o, 1'b0);
      check("pend_rst_dat", bus.wbs_dat_o, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_ack", bus.wbs_ack_o, 1'b1);
      check("post_rst_dat", bus.wbs_dat_o, 32'h0000_FFFF);
      // Reset while ack is high drops it at once
      #1 rst = 1'b1;
      #1;
      check("ackhi_rst_ack", bus.wbs_ack_o, 1'b0);
      check("ackhi_rst_dat", bus.wbs_dat_o, 32'd0);
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      // Randomized runs against the closed-form model
      for (int t = 0; t < 12; t++) begin
         int l, d, m;
         bit ar;
         l  = int'($urandom_range(0, MOD - 1));
         d  = int'($urandom_range(0, 12));
         m  = (l + d) % MOD;
         ar = 1'($urandom_range(0, 1));
         do_reset();
         wr(32'h4, 32'(l));
         wr(32'h8, 32'(m));
         wr(32'h0, ar ? 32'h9 : 32'h1);
         s = commit_cyc;
         check_run(l, m, ar, s, s + 18, $sformatf("rnd%0d", t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
